// File: rtl/ddr_region_init.sv
// Post-calibration DDR region fill with optional read-back verify.
// Build option: DDR_INIT_VERIFY_EN adds the read-back compare states.
module ddr_region_init #(
  parameter int          DATA_W       = 256,
  parameter int          ADDR_W       = 25,
  parameter int          BC_W         = 7,
  parameter int          BURST_LEN    = 64,
  parameter int          BASE_ADDR    = 0,
  parameter int          REGION_WORDS = 4096,
  parameter logic [31:0] SEED         = 32'hA5A5_0000,
  parameter int          CAL_TIMEOUT  = 1048576
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                local_cal_success,
  input  logic                local_cal_fail,
  input  logic                restart,
  output logic [ADDR_W-1:0]   amm_addr,
  output logic                amm_read,
  output logic                amm_write,
  output logic [DATA_W-1:0]   amm_writedata,
  output logic [DATA_W/8-1:0] amm_byteenable,
  output logic [BC_W-1:0]     amm_burstcount,
  input  logic                amm_ready,
  input  logic [DATA_W-1:0]   amm_readdata,
  input  logic                amm_readdatavalid,
  output logic                setup_done,
  output logic                setup_fail,
  output logic                busy,
  output logic [15:0]         err_count,
  output logic [31:0]         cycle_count
);

  localparam int LANES  = DATA_W / 32;
  localparam int NBURST = REGION_WORDS / BURST_LEN;

  if (DATA_W < 32 || DATA_W % 32 != 0 || BURST_LEN < 1 ||
      BURST_LEN > (1 << (BC_W - 1)) || REGION_WORDS < 1 ||
      REGION_WORDS % BURST_LEN != 0 || CAL_TIMEOUT < 1) begin : g_bad_params
    $error("ddr_region_init: illegal parameter set");
  end

  typedef enum logic [2:0] {
    WAIT_CAL,
    WRITE,
    VERIFY_CMD,
    VERIFY_DATA,
    DONE,
    FAIL
  } state_t;

  state_t      state, state_nx;
  logic [31:0] burst_cnt;
  logic [31:0] beat_cnt;
  logic [31:0] tmo_cnt;
  logic [31:0] word_idx;
  logic        cal_lost;
  logic        lost_now;
  logic        last_beat;
  logic        last_burst;
  logic        advance;
  logic        unused_idx;

  function automatic logic [DATA_W-1:0] pattern(input logic [23:0] w);
    logic [DATA_W-1:0] p;
    p = '0;
    for (int k = 0; k < LANES; k++) begin
      p[k*32 +: 32] = SEED ^ {w, 8'(k)};
    end
    return p;
  endfunction

  assign word_idx   = burst_cnt * BURST_LEN + beat_cnt;
  assign unused_idx = ^word_idx[31:24];
  assign lost_now   = cal_lost | ~local_cal_success;
  assign last_beat  = beat_cnt == BURST_LEN - 1;
  assign last_burst = burst_cnt == NBURST - 1;

  assign busy = state == WRITE || state == VERIFY_CMD ||
                state == VERIFY_DATA;
  assign setup_done     = state == DONE;
  assign setup_fail     = state == FAIL;
  assign amm_write      = state == WRITE;
  assign amm_byteenable = '1;
  assign amm_burstcount = BC_W'(BURST_LEN);
  assign amm_writedata  = amm_write ? pattern(word_idx[23:0]) : '0;
  assign amm_addr = (amm_write || amm_read) ?
                    ADDR_W'(BASE_ADDR + burst_cnt * BURST_LEN) : '0;

`ifdef DDR_INIT_VERIFY_EN
  logic mismatch;

  assign amm_read = state == VERIFY_CMD;
  assign mismatch = amm_readdata != pattern(word_idx[23:0]);
  assign advance  = (state == WRITE && amm_ready) ||
                    (state == VERIFY_DATA && amm_readdatavalid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if ((setup_done || setup_fail) && restart) begin
      err_count <= '0;
    end else if (state == VERIFY_DATA && amm_readdatavalid &&
                 mismatch && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'd1;
    end
  end
`else
  logic unused_rd;

  assign amm_read  = 1'b0;
  assign err_count = '0;
  assign advance   = state == WRITE && amm_ready;
  assign unused_rd = ^{amm_readdata, amm_readdatavalid};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= WAIT_CAL;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      WAIT_CAL: begin
        if (local_cal_fail)                state_nx = FAIL;
        else if (local_cal_success)        state_nx = WRITE;
        else if (tmo_cnt == CAL_TIMEOUT-1) state_nx = FAIL;
      end
      WRITE: begin
        if (amm_ready && last_beat) begin
          if (lost_now)        state_nx = FAIL;
`ifdef DDR_INIT_VERIFY_EN
          else if (last_burst) state_nx = VERIFY_CMD;
`else
          else if (last_burst) state_nx = DONE;
`endif
        end
      end
`ifdef DDR_INIT_VERIFY_EN
      VERIFY_CMD: begin
        if (amm_ready) state_nx = VERIFY_DATA;
      end
      VERIFY_DATA: begin
        if (amm_readdatavalid && last_beat) begin
          if (lost_now)                         state_nx = FAIL;
          else if (!last_burst)                 state_nx = VERIFY_CMD;
          else if (mismatch || err_count != 0)  state_nx = FAIL;
          else                                  state_nx = DONE;
        end
      end
`endif
      DONE, FAIL: begin
        if (restart) state_nx = WAIT_CAL;
      end
      default: state_nx = WAIT_CAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burst_cnt   <= '0;
      beat_cnt    <= '0;
      tmo_cnt     <= '0;
      cal_lost    <= 1'b0;
      cycle_count <= '0;
    end else begin
      tmo_cnt <= (state == WAIT_CAL) ? tmo_cnt + 32'd1 : '0;
      if (state == WAIT_CAL) begin
        burst_cnt <= '0;
        beat_cnt  <= '0;
        cal_lost  <= 1'b0;
        if (state_nx == WRITE) cycle_count <= '0;
      end
      if (busy) begin
        if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
        if (!local_cal_success) cal_lost <= 1'b1;
      end
      // burst index wraps to 0 so verify restarts at the region base
      if (advance) begin
        if (last_beat) begin
          beat_cnt  <= '0;
          burst_cnt <= last_burst ? '0 : burst_cnt + 32'd1;
        end else begin
          beat_cnt <= beat_cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr_region_init.sv
// Directed bench for ddr_region_init: fill, backpressure, cal fail/timeout,
// cal loss, restart and (with DDR_INIT_VERIFY_EN) read-back verify.
module tb_ddr_region_init;

  localparam int          DW   = 64;
  localparam int          AW   = 25;
  localparam int          BW   = 7;
  localparam int          BL   = 4;
  localparam int          BASE = 'h100;
  localparam int          RW   = 16;
  localparam int          CT   = 50;
  localparam logic [31:0] SEED = 32'hA5A50000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cal_ok = 1'b0;
  logic          cal_bad = 1'b0;
  logic          restart = 1'b0;
  logic          amm_ready = 1'b1;
  logic          rdv = 1'b0;
  logic [DW-1:0] rdata = '0;

  logic [AW-1:0]   amm_addr;
  logic            amm_read;
  logic            amm_write;
  logic [DW-1:0]   amm_writedata;
  logic [DW/8-1:0] amm_byteenable;
  logic [BW-1:0]   amm_burstcount;
  logic            setup_done;
  logic            setup_fail;
  logic            busy;
  logic [15:0]     err_count;
  logic [31:0]     cycle_count;

  ddr_region_init #(
    .DATA_W(DW), .ADDR_W(AW), .BC_W(BW), .BURST_LEN(BL),
    .BASE_ADDR(BASE), .REGION_WORDS(RW), .SEED(SEED),
    .CAL_TIMEOUT(CT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .local_cal_success(cal_ok),
    .local_cal_fail(cal_bad),
    .restart(restart),
    .amm_addr(amm_addr),
    .amm_read(amm_read),
    .amm_write(amm_write),
    .amm_writedata(amm_writedata),
    .amm_byteenable(amm_byteenable),
    .amm_burstcount(amm_burstcount),
    .amm_ready(amm_ready),
    .amm_readdata(rdata),
    .amm_readdatavalid(rdv),
    .setup_done(setup_done),
    .setup_fail(setup_fail),
    .busy(busy),
    .err_count(err_count),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int            wbeats, wr_cycles, stalls, stall_bad, data_bad;
  int            tcount, rd_left, rd_addr, n;
  int            corrupt_addr = -1;
  logic          bp_mode = 1'b0;
  logic          prev_stall;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data;
  logic [31:0]   beat5_lane0;
  logic [AW-1:0] baddr[$];
  logic [DW-1:0] mem[int];

  function automatic logic [DW-1:0] exp_word(input int w);
    logic [DW-1:0] v;
    logic [23:0]   wl;
    wl = w[23:0];
    for (int k = 0; k < DW/32; k++) v[k*32 +: 32] = SEED ^ {wl, 8'(k)};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wbeats = 0; wr_cycles = 0; stalls = 0; stall_bad = 0;
    data_bad = 0; prev_stall = 1'b0; beat5_lane0 = '0;
    baddr.delete();
  endtask

  task automatic tick();
    @(negedge clk);
    if (amm_write) begin
      wr_cycles++;
      if (prev_stall && (amm_addr !== p_addr || amm_writedata !== p_data))
        stall_bad++;
      if (amm_ready) begin
        if (wbeats % BL == 0) baddr.push_back(amm_addr);
        if (amm_writedata !== exp_word(int'(amm_addr) + wbeats % BL - BASE))
          data_bad++;
        if (wbeats == 5) beat5_lane0 = amm_writedata[31:0];
        mem[int'(amm_addr) + wbeats % BL] = amm_writedata;
        wbeats++;
        prev_stall = 1'b0;
      end else begin
        stalls++;
        prev_stall = 1'b1;
        p_addr = amm_addr;
        p_data = amm_writedata;
      end
    end else begin
      prev_stall = 1'b0;
    end
    if (amm_read && amm_ready) begin
      rd_left = BL;
      rd_addr = int'(amm_addr);
    end
    @(posedge clk);
    #1;
    tcount++;
    amm_ready = bp_mode ? (tcount % 4 == 0 || tcount % 4 == 3) : 1'b1;
    if (rd_left > 0) begin
      rdv   = 1'b1;
      rdata = mem.exists(rd_addr) ? mem[rd_addr] : '0;
      if (rd_addr == corrupt_addr) rdata[0] = ~rdata[0];
      rd_addr++;
      rd_left--;
    end else begin
      rdv   = 1'b0;
      rdata = '0;
    end
  endtask

  task automatic run_to_end(input int budget, input string tag);
    int cnt;
    cnt = 0;
    while (!(setup_done === 1'b1 || setup_fail === 1'b1) && cnt < budget) begin
      tick();
      cnt++;
    end
    chk({tag, "_terminates"}, 64'(cnt < budget), 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rd_left = 0;
    repeat (3) tick();
    clear_mon();
    rst_n = 1'b1;
  endtask

  initial begin
    tcount = 0;
    rd_left = 0;
    clear_mon();

    repeat (3) tick();
    chk("rst_done", 64'(setup_done), 64'd0);
    chk("rst_fail", 64'(setup_fail), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_write", 64'(amm_write), 64'd0);
    chk("rst_read", 64'(amm_read), 64'd0);
    chk("rst_addr", 64'(amm_addr), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    chk("rst_cycles", 64'(cycle_count), 64'd0);
    chk("rst_byteen", 64'(amm_byteenable), 64'hFF);
    chk("rst_burstcnt", 64'(amm_burstcount), 64'd4);

    rst_n = 1'b1;
    repeat (10) tick();
    chk("wait_idle", 64'({busy, setup_done, setup_fail}), 64'd0);
    cal_ok = 1'b1;
    run_to_end(200, "normal");
    chk("normal_done", 64'(setup_done), 64'd1);
    chk("normal_fail", 64'(setup_fail), 64'd0);
    chk("normal_beats", 64'(wbeats), 64'd16);
    chk("normal_nbursts", 64'(baddr.size()), 64'd4);
    chk("normal_addr0", 64'(baddr[0]), 64'h100);
    chk("normal_addr1", 64'(baddr[1]), 64'h104);
    chk("normal_addr2", 64'(baddr[2]), 64'h108);
    chk("normal_addr3", 64'(baddr[3]), 64'h10C);
    chk("normal_beat5", 64'(beat5_lane0), 64'hA5A50500);
    chk("normal_data", 64'(data_bad), 64'd0);
    chk("normal_err", 64'(err_count), 64'd0);
`ifdef DDR_INIT_VERIFY_EN
    chk("normal_cycles", 64'(cycle_count), 64'd36);
`else
    chk("normal_cycles", 64'(cycle_count), 64'd16);
`endif
    repeat (3) tick();
    chk("done_hold", 64'(setup_done), 64'd1);
`ifdef DDR_INIT_VERIFY_EN
    chk("cycles_frozen", 64'(cycle_count), 64'd36);
`else
    chk("cycles_frozen", 64'(cycle_count), 64'd16);
`endif

    cal_ok = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rst_from_done", 64'({setup_done, setup_fail, busy}), 64'd0);
    repeat (2) tick();
    chk("wait_after_restart", 64'({busy, amm_write}), 64'd0);

    bp_mode = 1'b1;
    clear_mon();
    cal_ok = 1'b1;
    repeat (6) tick();
    chk("bp_busy", 64'(busy), 64'd1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_ignored", 64'({busy, setup_done}), 64'b10);
    run_to_end(400, "bp");
    chk("bp_done", 64'(setup_done), 64'd1);
    chk("bp_beats", 64'(wbeats), 64'd16);
    chk("bp_stable", 64'(stall_bad), 64'd0);
    chk("bp_stalled", 64'(stalls > 0), 64'd1);
    chk("bp_data", 64'(data_bad), 64'd0);
    chk("bp_addr3", 64'(baddr[3]), 64'h10C);
    bp_mode = 1'b0;

    cal_ok = 1'b1;
    cal_bad = 1'b1;
    do_reset();
    run_to_end(20, "calfail");
    chk("calfail_fail", 64'(setup_fail), 64'd1);
    chk("calfail_done", 64'(setup_done), 64'd0);
    chk("calfail_nowrite", 64'(wr_cycles), 64'd0);

    cal_bad = 1'b0;
    cal_ok = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rst_from_fail", 64'({setup_fail, busy}), 64'd0);
    chk("rst_err_clear", 64'(err_count), 64'd0);
    n = 0;
    while (setup_fail !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 64'(n), 64'd50);
    chk("timeout_nowrite", 64'(wr_cycles), 64'd0);

    restart = 1'b1;
    tick();
    restart = 1'b0;
    clear_mon();
    cal_ok = 1'b1;
    run_to_end(200, "rerun");
    chk("rerun_done", 64'(setup_done), 64'd1);
    chk("rerun_beats", 64'(wbeats), 64'd16);

    cal_ok = 1'b1;
    do_reset();
    n = 0;
    while (wbeats != 10 && n < 100) begin
      tick();
      n++;
    end
    chk("lost_reach_beat10", 64'(wbeats), 64'd10);
    cal_ok = 1'b0;
    run_to_end(100, "lost");
    chk("lost_fail", 64'(setup_fail), 64'd1);
    chk("lost_done", 64'(setup_done), 64'd0);
    chk("lost_beats", 64'(wbeats), 64'd12);
    chk("lost_nbursts", 64'(baddr.size()), 64'd3);
    chk("lost_addr2", 64'(baddr[2]), 64'h108);

`ifdef DDR_INIT_VERIFY_EN
    corrupt_addr = 'h106;
    cal_ok = 1'b1;
    do_reset();
    run_to_end(300, "vcorrupt");
    chk("vcorrupt_err", 64'(err_count), 64'd1);
    chk("vcorrupt_fail", 64'(setup_fail), 64'd1);
    chk("vcorrupt_done", 64'(setup_done), 64'd0);

    corrupt_addr = -1;
    do_reset();
    run_to_end(300, "vclean");
    chk("vclean_err", 64'(err_count), 64'd0);
    chk("vclean_done", 64'(setup_done), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_region_init.md
Name: ddr_region_init

Overview:
- Parametrised successor to the DDR setup block.
- After DDR calibration succeeds, it fills a configurable DDR region with a deterministic pattern using Avalon-MM write bursts.
- Optionally reads the region back and compares it against the pattern.
- Reports done/fail status, an error count and a cycle count. It sits between the EMIF status outputs and the Avalon-MM master port ahead of the main datapath, and gates the system out of reset.

Parameters:
- DATA_W, 256, Avalon data width; multiple of 32.
- ADDR_W, 25, Avalon word address width.
- BC_W, 7, burstcount width.
- BURST_LEN, 64, beats per burst; 1..2^(BC_W-1).
- BASE_ADDR, 0, first word address of the region.
- REGION_WORDS, 4096, words to initialise; nonzero multiple of BURST_LEN.
- SEED, 32'hA5A5_0000, pattern seed.
- CAL_TIMEOUT, 1048576, cycles to wait for calibration before failing.

Ports:
- clk, in, 1, single clock (Avalon clock domain).
- rst_n, in, 1, synchronous active-low reset.
- local_cal_success, in, 1, EMIF calibration passed.
- local_cal_fail, in, 1, EMIF calibration failed.
- restart, in, 1, single-cycle pulse; reruns the sequence from DONE or FAIL.
- amm_addr, out, ADDR_W, burst start word address.
- amm_read, out, 1, read request.
- amm_write, out, 1, write request.
- amm_writedata, out, DATA_W, write beat data.
- amm_byteenable, out, DATA_W/8, all ones.
- amm_burstcount, out, BC_W, equals BURST_LEN.
- amm_ready, in, 1, slave accepts the command/beat this cycle (1 = accept).
- amm_readdata, in, DATA_W, read beat data.
- amm_readdatavalid, in, 1, read beat valid.
- setup_done, out, 1, region initialised (and verified when enabled).
- setup_fail, out, 1, calibration fail, calibration timeout, calibration lost, or verify mismatch.
- busy, out, 1, high in WRITE or VERIFY states.
- err_count, out, 16, saturating mismatch count.
- cycle_count, out, 32, cycles from cal success to DONE/FAIL; saturating.

Behaviour:
- Reset (rst_n low at clk edge): state WAIT_CAL; all outputs 0; amm_byteenable all ones; amm_burstcount = BURST_LEN.
- Reset mid-burst abandons the burst. The interconnect is reset alongside this block.
- Pattern: word index w = address - BASE_ADDR. 32-bit lane k of the word = SEED ^ {w[23:0], k[7:0]}.
- WAIT_CAL:
  - Timeout counter increments each cycle.
  - local_cal_fail=1 -> FAIL. This has priority over success in the same cycle.
  - Counter reaching CAL_TIMEOUT-1 without success -> FAIL.
  - local_cal_success=1 -> WRITE; burst/beat counters cleared; cycle_count cleared and starts counting.
- WRITE:
  - amm_write=1 and amm_writedata = pattern for the current beat.
  - amm_addr = BASE_ADDR + burst*BURST_LEN, held constant for the whole burst.
  - A beat advances only on a cycle with amm_ready=1; otherwise all outputs are held.
  - After the last beat of a burst, amm_write may drop for at most one cycle before the next burst.
  - After the last beat of the last burst -> VERIFY_CMD (macro defined) or DONE (macro undefined).
- Cal loss: local_cal_success low during WRITE/VERIFY sets a sticky cal_lost flag. The current burst completes (writes) or drains (reads), then the state goes to FAIL.
- DONE: setup_done=1, busy=0, cycle_count frozen. Holds until reset or restart.
- FAIL: setup_fail=1, busy=0, cycle_count frozen. Holds until reset or restart.
- restart:
  - In DONE/FAIL: next cycle goes to WAIT_CAL; clears setup_done, setup_fail, err_count and the timeout counter.
  - In any other state: ignored.
- Wrap: amm_addr arithmetic is modulo 2^ADDR_W. Parameter legality is checked by an elaboration assertion.

Optional Feature:
- Macro: DDR_INIT_VERIFY_EN.
- Defined, adds VERIFY_CMD and VERIFY_DATA states:
  - VERIFY_CMD: amm_read=1 with the burst address, held until amm_ready=1. Then -> VERIFY_DATA.
  - VERIFY_DATA: each amm_readdatavalid beat is compared to the expected pattern. Any lane mismatch increments err_count by 1 per beat, saturating at 16'hFFFF. readdatavalid outside VERIFY_DATA is ignored.
  - After BURST_LEN beats: next burst -> VERIFY_CMD; or, after the last burst, err_count==0 -> DONE, else -> FAIL.
  - One read burst is outstanding at a time.
- Undefined: no read logic; amm_read tied 0; err_count tied 0.

Test Plan:
- Setup for all scenarios: DATA_W=64, BURST_LEN=4, REGION_WORDS=16, BASE_ADDR=0x100, SEED=0xA5A50000.
- Normal run: cal_success high at cycle 10, amm_ready always 1 -> 4 write bursts at 0x100/0x104/0x108/0x10C, 16 write beats; beat 5 data lane0 = 0xA5A50500; setup_done=1, setup_fail=0.
- Backpressure: amm_ready toggles 1,0,0,1 -> amm_addr and amm_writedata stable during stalls; exactly 16 accepted beats; setup_done asserted.
- Cal fail: local_cal_fail=1 with local_cal_success=1 in the same cycle -> FAIL, amm_write never asserted. Cal timeout with CAL_TIMEOUT=50 -> setup_fail at cycle 50.
- Verify (DDR_INIT_VERIFY_EN): memory model corrupts word 0x106 -> err_count=1, setup_fail=1. Clean memory -> err_count=0, setup_done=1.
- Cal lost: local_cal_success drops mid burst 2 -> burst 2 completes all 4 beats, burst 3 never issued, setup_fail=1.
- Restart: pulse in FAIL -> flags clear next cycle, state WAIT_CAL, full sequence reruns; restart pulsed during WRITE is ignored.
